// File: rtl/systolic_skew_feeder.sv
// -----------------------------------------------------------------------------
// systolic_skew_feeder
//
// Input-side operand feeder for the systolic tile array. Accepts a
// MATRIX_SIZE x MATRIX_SIZE operand matrix one row per handshake, holds up to
// two complete matrices in a pair of banks, and streams each matrix into the
// array's MATRIX_SIZE lanes diagonally skewed over ARRAY_SIZE = 2*MATRIX_SIZE-1
// steps. Loading one bank overlaps with streaming the other.
//
// Handshake (load side): a row transfers on a rising clk edge where
// in_valid && in_ready are both high. The producer must hold in_row stable while
// in_valid is high and not yet accepted; in_ready does not depend on in_valid.
//
// Ports
//   clk            single clock, rising edge
//   reset          asynchronous, active-low reset
//   enable         stream advance; low stalls the stream
//   in_valid       in_row holds a valid row
//   in_ready       feeder can accept a row (registered)
//   in_row         row r, lane c at [c*DATA_WIDTH +: DATA_WIDTH]
//   out_valid      out_data / out_lane_valid hold a fresh step
//   out_lane_valid per-lane element valid
//   out_data       lane j at [j*DATA_WIDTH +: DATA_WIDTH]
//   out_first      high with step 0 of a matrix
//   out_last       high with step ARRAY_SIZE-1 of a matrix
//   busy           stream FSM is in STREAM (exposes the FSM state)
// -----------------------------------------------------------------------------
module systolic_skew_feeder #(
   parameter int MATRIX_SIZE = 4,
   parameter int DATA_WIDTH  = 16
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              enable,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [MATRIX_SIZE*DATA_WIDTH-1:0] in_row,
   output logic                              out_valid,
   output logic [MATRIX_SIZE-1:0]            out_lane_valid,
   output logic [MATRIX_SIZE*DATA_WIDTH-1:0] out_data,
   output logic                              out_first,
   output logic                              out_last,
   output logic                              busy
);

   localparam int ARRAY_SIZE = 2*MATRIX_SIZE - 1;
   localparam int TW = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
   localparam int RW = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;
   localparam int ROW_W = MATRIX_SIZE*DATA_WIDTH;

   localparam logic [TW-1:0] T_LAST   = TW'(ARRAY_SIZE - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(MATRIX_SIZE - 1);

   localparam logic [0:0] S_IDLE   = 1'b0;
   localparam logic [0:0] S_STREAM = 1'b1;

   // Operand storage: two banks of MATRIX_SIZE rows. Not reset; the full
   // flags qualify every read.
   logic [ROW_W-1:0] bank_q [2][MATRIX_SIZE];

   logic [0:0]            state_q,          state_d;
   logic [1:0]            full_q,           full_d;
   logic                  wr_bank_q,        wr_bank_d;
   logic                  rd_bank_q,        rd_bank_d;
   logic [RW-1:0]         wr_row_q,         wr_row_d;
   logic [TW-1:0]         t_q,              t_d;
   logic                  in_ready_q,       in_ready_d;
   logic                  out_valid_q,      out_valid_d;
   logic [MATRIX_SIZE-1:0] out_lane_valid_q, out_lane_valid_d;
   logic [ROW_W-1:0]      out_data_q,       out_data_d;
   logic                  out_first_q,      out_first_d;
   logic                  out_last_q,       out_last_d;

   logic load_fire;
   logic stream_go;
   logic step_last;

   // in_ready_q mirrors !full[wr_bank] one edge late only right after reset,
   // so qualifying with it keeps the handshake honest on that first edge.
   assign load_fire = in_valid && in_ready_q;

   // In STREAM the read bank is always full, so this also covers the
   // IDLE -> STREAM start condition.
   assign stream_go = enable && ((state_q == S_STREAM) || full_q[rd_bank_q]);
   assign step_last = (t_q == T_LAST);

   always_comb begin
      int row_i;
      row_i            = 0;
      state_d          = state_q;
      full_d           = full_q;
      wr_bank_d        = wr_bank_q;
      rd_bank_d        = rd_bank_q;
      wr_row_d         = wr_row_q;
      t_d              = t_q;
      out_valid_d      = out_valid_q;
      out_lane_valid_d = out_lane_valid_q;
      out_data_d       = out_data_q;
      out_first_d      = out_first_q;
      out_last_d       = out_last_q;

      // ---------------- stream side ----------------
      if (stream_go) begin
         out_valid_d = 1'b1;
         out_first_d = (t_q == '0);
         out_last_d  = step_last;
         // Step t: lane j carries row (t-j), column j of the read bank.
         for (int j = 0; j < MATRIX_SIZE; j++) begin
            row_i = int'(t_q) - j;
            if (row_i >= 0 && row_i < MATRIX_SIZE) begin
               out_lane_valid_d[j]                      = 1'b1;
               out_data_d[j*DATA_WIDTH +: DATA_WIDTH]   =
                  bank_q[rd_bank_q][RW'(row_i)][j*DATA_WIDTH +: DATA_WIDTH];
            end else begin
               out_lane_valid_d[j]                      = 1'b0;
               out_data_d[j*DATA_WIDTH +: DATA_WIDTH]   = '0;
            end
         end
         if (step_last) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
            t_d               = '0;
            // Back-to-back matrices: no bubble when the other bank is ready.
            state_d           = full_q[~rd_bank_q] ? S_STREAM : S_IDLE;
         end else begin
            t_d     = t_q + 1'b1;
            state_d = S_STREAM;
         end
      end else if (state_q == S_STREAM) begin
         // Stall: everything holds except the valid strobe.
         out_valid_d = 1'b0;
      end else begin
         out_valid_d      = 1'b0;
         out_lane_valid_d = '0;
         out_first_d      = 1'b0;
         out_last_d       = 1'b0;
      end

      // ---------------- load side ----------------
      // Load and stream never touch the same bank: the write bank is empty
      // and the read bank is full, so both flag updates can land together.
      if (load_fire) begin
         if (wr_row_q == ROW_LAST) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
            wr_row_d          = '0;
         end else begin
            wr_row_d = wr_row_q + 1'b1;
         end
      end

      in_ready_d = !full_d[wr_bank_d];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q          <= S_IDLE;
         full_q           <= '0;
         wr_bank_q        <= 1'b0;
         rd_bank_q        <= 1'b0;
         wr_row_q         <= '0;
         t_q              <= '0;
         in_ready_q       <= 1'b0;
         out_valid_q      <= 1'b0;
         out_lane_valid_q <= '0;
         out_data_q       <= '0;
         out_first_q      <= 1'b0;
         out_last_q       <= 1'b0;
      end else begin
         state_q          <= state_d;
         full_q           <= full_d;
         wr_bank_q        <= wr_bank_d;
         rd_bank_q        <= rd_bank_d;
         wr_row_q         <= wr_row_d;
         t_q              <= t_d;
         in_ready_q       <= in_ready_d;
         out_valid_q      <= out_valid_d;
         out_lane_valid_q <= out_lane_valid_d;
         out_data_q       <= out_data_d;
         out_first_q      <= out_first_d;
         out_last_q       <= out_last_d;
      end
   end

   always_ff @(posedge clk) begin
      if (load_fire) begin
         bank_q[wr_bank_q][wr_row_q] <= in_row;
      end
   end

   assign in_ready       = in_ready_q;
   assign out_valid      = out_valid_q;
   assign out_lane_valid = out_lane_valid_q;
   assign out_data       = out_data_q;
   assign out_first      = out_first_q;
   assign out_last       = out_last_q;
   assign busy           = (state_q == S_STREAM);

endmodule
